phv_stage_fifo: RTL and testbench



---
 rtl/phv_stage_fifo.sv | 263 ++++++++++++++++++++++++++
 tb/tb_phv_stage_fifo.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phv_stage_fifo.sv
// phv_stage_fifo
// Pipeline-stage PHV buffer: a DEPTH-entry first-word-fall-through FIFO
// between stages, plus an in-band control-path snooper. Control packets whose
// first beat carries this stage's module ID reconfigure the block (NORMAL/DROP
// mode, statistics clear) and are swallowed. All other packets are forwarded
// unchanged with one cycle of latency.
module phv_stage_fifo #(
    parameter int C_S_AXIS_DATA_WIDTH  = 512,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int STAGE_ID             = 0,
    parameter int PHV_LEN              = 1024,
    parameter int DEPTH                = 4,
    parameter int CNT_WIDTH            = 32
) (
    input  logic                              axis_clk,
    input  logic                              areset,

    // PHV path
    input  logic [PHV_LEN-1:0]                phv_in,
    input  logic                              phv_in_valid,
    output logic                              stage_ready_out,
    output logic [PHV_LEN-1:0]                phv_out,
    output logic                              phv_out_valid,
    input  logic                              stage_ready_in,

    // Control path in
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    c_s_axis_tdata,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_s_axis_tuser,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_s_axis_tkeep,
    input  logic                              c_s_axis_tvalid,
    input  logic                              c_s_axis_tlast,

    // Control path out
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    c_m_axis_tdata,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_m_axis_tuser,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_m_axis_tkeep,
    output logic                              c_m_axis_tvalid,
    output logic                              c_m_axis_tlast,

    // Statistics
    output logic [CNT_WIDTH-1:0]              pass_cnt,
    output logic [CNT_WIDTH-1:0]              drop_cnt
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    // Module ID matched against tdata[15:8] of a packet's first beat.
    localparam logic [7:0] MOD_ID  = {5'(STAGE_ID), 3'b111};

    typedef enum logic {
        MODE_NORMAL,
        MODE_DROP
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE,     // waiting for the first beat of a control packet
        ST_FWD,      // forwarding the rest of a foreign packet
        ST_CONSUME   // swallowing the rest of a packet addressed to us
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PHV_LEN-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count_q,  count_d;

    mode_t              mode_q,   mode_d;
    state_t             state_q,  state_d;

    logic [CNT_WIDTH-1:0] pass_q, pass_d;
    logic [CNT_WIDTH-1:0] drop_q, drop_d;

    logic [C_S_AXIS_DATA_WIDTH-1:0]   c_tdata_q;
    logic [C_S_AXIS_TUSER_WIDTH-1:0]  c_tuser_q;
    logic [C_S_AXIS_DATA_WIDTH/8-1:0] c_tkeep_q;
    logic                             c_tvalid_q;
    logic                             c_tlast_q;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic push;
    logic pop;
    logic drop_ev;
    logic fwd_beat;
    logic clr_cnt;
    logic [7:0] beat_id;
    logic [1:0] cfg_code;

    assign beat_id  = c_s_axis_tdata[15:8];
    assign cfg_code = c_s_axis_tdata[17:16];

    // In DROP mode the stage always accepts, so upstream never stalls on us.
    assign stage_ready_out = (mode_q == MODE_DROP) ? 1'b1 : (count_q < DEPTH_C);
    assign phv_out_valid   = (count_q != '0);
    // Gate with valid so the output reads as zero while empty and after reset.
    assign phv_out         = phv_out_valid ? mem_q[rd_ptr_q] : '0;

    assign push    = phv_in_valid && stage_ready_out && (mode_q == MODE_NORMAL);
    assign pop     = phv_out_valid && stage_ready_in;
    assign drop_ev = phv_in_valid && (mode_q == MODE_DROP);

    // FIFO pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO storage write; no reset so it maps onto plain RAM/LUT storage.
    always_ff @(posedge axis_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= phv_in;
        end
    end

    // FIFO pointer and occupancy registers.
    always_ff @(posedge axis_clk or posedge areset) begin
        if (areset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Control-path FSM
    // ------------------------------------------------------------------

    // Next-state, config decode and forward decision for the current beat.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        fwd_beat = 1'b0;
        clr_cnt  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (c_s_axis_tvalid) begin
                    if (beat_id == MOD_ID) begin
                        unique case (cfg_code)
                            2'b00:   mode_d  = MODE_NORMAL;
                            2'b01:   mode_d  = MODE_DROP;
                            2'b10:   clr_cnt = 1'b1;
                            default: mode_d  = mode_q;
                        endcase
                        if (!c_s_axis_tlast) begin
                            state_d = ST_CONSUME;
                        end
                    end else begin
                        fwd_beat = 1'b1;
                        if (!c_s_axis_tlast) begin
                            state_d = ST_FWD;
                        end
                    end
                end
            end
            ST_FWD: begin
                // Later beats are never inspected for an ID; they just follow.
                if (c_s_axis_tvalid) begin
                    fwd_beat = 1'b1;
                    if (c_s_axis_tlast) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_CONSUME: begin
                if (c_s_axis_tvalid && c_s_axis_tlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state and operating-mode registers.
    always_ff @(posedge axis_clk or posedge areset) begin
        if (areset) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_NORMAL;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
        end
    end

    // Registered control-path output; payload only reloads on forwarded beats.
    always_ff @(posedge axis_clk or posedge areset) begin
        if (areset) begin
            c_tdata_q  <= '0;
            c_tuser_q  <= '0;
            c_tkeep_q  <= '0;
            c_tvalid_q <= 1'b0;
            c_tlast_q  <= 1'b0;
        end else begin
            c_tvalid_q <= fwd_beat;
            if (fwd_beat) begin
                c_tdata_q <= c_s_axis_tdata;
                c_tuser_q <= c_s_axis_tuser;
                c_tkeep_q <= c_s_axis_tkeep;
                c_tlast_q <= c_s_axis_tlast;
            end
        end
    end

    assign c_m_axis_tdata  = c_tdata_q;
    assign c_m_axis_tuser  = c_tuser_q;
    assign c_m_axis_tkeep  = c_tkeep_q;
    assign c_m_axis_tvalid = c_tvalid_q;
    assign c_m_axis_tlast  = c_tlast_q;

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------

    // Saturating counters; a clear beat overrides any same-cycle increment.
    always_comb begin
        pass_d = pass_q;
        drop_d = drop_q;
        if (clr_cnt) begin
            pass_d = '0;
            drop_d = '0;
        end else begin
            if (pop && (pass_q != '1)) begin
                pass_d = pass_q + 1'b1;
            end
            if (drop_ev && (drop_q != '1)) begin
                drop_d = drop_q + 1'b1;
            end
        end
    end

    // Statistics counter registers.
    always_ff @(posedge axis_clk or posedge areset) begin
        if (areset) begin
            pass_q <= '0;
            drop_q <= '0;
        end else begin
            pass_q <= pass_d;
            drop_q <= drop_d;
        end
    end

    assign pass_cnt = pass_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_phv_stage_fifo.sv
// tb_phv_stage_fifo
// Directed bench for phv_stage_fifo with a queue-based reference model and
// a per-cycle compare, plus literal expectations at key scenario points.
module tb_phv_stage_fifo;

    localparam int DW    = 64;
    localparam int UW    = 32;
    localparam int KW    = DW / 8;
    localparam int PL    = 64;
    localparam int DEPTH = 4;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;
    localparam logic [7:0] MOD = 8'h17;   // STAGE_ID=2 -> {5'd2,3'b111}

    logic          clk;
    logic          areset;
    logic [PL-1:0] phv_in;
    logic          phv_in_valid;
    logic          stage_ready_out;
    logic [PL-1:0] phv_out;
    logic          phv_out_valid;
    logic          stage_ready_in;
    logic [DW-1:0] c_s_axis_tdata;
    logic [UW-1:0] c_s_axis_tuser;
    logic [KW-1:0] c_s_axis_tkeep;
    logic          c_s_axis_tvalid;
    logic          c_s_axis_tlast;
    logic [DW-1:0] c_m_axis_tdata;
    logic [UW-1:0] c_m_axis_tuser;
    logic [KW-1:0] c_m_axis_tkeep;
    logic          c_m_axis_tvalid;
    logic          c_m_axis_tlast;
    logic [CW-1:0] pass_cnt;
    logic [CW-1:0] drop_cnt;

    phv_stage_fifo #(
        .C_S_AXIS_DATA_WIDTH (DW),
        .C_S_AXIS_TUSER_WIDTH(UW),
        .STAGE_ID            (2),
        .PHV_LEN             (PL),
        .DEPTH               (DEPTH),
        .CNT_WIDTH           (CW)
    ) dut (
        .axis_clk       (clk),
        .areset         (areset),
        .phv_in         (phv_in),
        .phv_in_valid   (phv_in_valid),
        .stage_ready_out(stage_ready_out),
        .phv_out        (phv_out),
        .phv_out_valid  (phv_out_valid),
        .stage_ready_in (stage_ready_in),
        .c_s_axis_tdata (c_s_axis_tdata),
        .c_s_axis_tuser (c_s_axis_tuser),
        .c_s_axis_tkeep (c_s_axis_tkeep),
        .c_s_axis_tvalid(c_s_axis_tvalid),
        .c_s_axis_tlast (c_s_axis_tlast),
        .c_m_axis_tdata (c_m_axis_tdata),
        .c_m_axis_tuser (c_m_axis_tuser),
        .c_m_axis_tkeep (c_m_axis_tkeep),
        .c_m_axis_tvalid(c_m_axis_tvalid),
        .c_m_axis_tlast (c_m_axis_tlast),
        .pass_cnt       (pass_cnt),
        .drop_cnt       (drop_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a queue of PHVs, a drop flag, packet-tracking bits
    // and integer statistics.
    // ------------------------------------------------------------------
    logic [PL-1:0] mq[$];
    bit            m_drop_mode;
    bit            m_in_pkt;
    bit            m_swallow;
    int            m_pass;
    int            m_drop;
    bit            m_cv;
    logic [DW-1:0] m_cd;
    logic [UW-1:0] m_cu;
    logic [KW-1:0] m_ck;
    bit            m_cl;
    bit            mv_pop, mv_push, mv_drop, mv_clr, mv_next_drop;

    always @(posedge clk or posedge areset) begin
        if (areset) begin
            mq.delete();
            m_drop_mode = 1'b0;
            m_in_pkt    = 1'b0;
            m_swallow   = 1'b0;
            m_pass      = 0;
            m_drop      = 0;
            m_cv        = 1'b0;
            m_cd        = '0;
            m_cu        = '0;
            m_ck        = '0;
            m_cl        = 1'b0;
        end else begin
            mv_pop       = (mq.size() != 0) && stage_ready_in;
            mv_push      = phv_in_valid && !m_drop_mode && (mq.size() < DEPTH);
            mv_drop      = phv_in_valid && m_drop_mode;
            mv_clr       = 1'b0;
            mv_next_drop = m_drop_mode;
            m_cv         = 1'b0;
            if (c_s_axis_tvalid) begin
                if (!m_in_pkt) begin
                    m_swallow = (c_s_axis_tdata[15:8] == MOD);
                    if (m_swallow) begin
                        case (c_s_axis_tdata[17:16])
                            2'b00:   mv_next_drop = 1'b0;
                            2'b01:   mv_next_drop = 1'b1;
                            2'b10:   mv_clr = 1'b1;
                            default: mv_next_drop = m_drop_mode;
                        endcase
                    end
                    m_in_pkt = !c_s_axis_tlast;
                end else if (c_s_axis_tlast) begin
                    m_in_pkt = 1'b0;
                end
                if (!m_swallow) begin
                    m_cv = 1'b1;
                    m_cd = c_s_axis_tdata;
                    m_cu = c_s_axis_tuser;
                    m_ck = c_s_axis_tkeep;
                    m_cl = c_s_axis_tlast;
                end
            end
            if (mv_pop && m_pass < CMAX) m_pass++;
            if (mv_drop && m_drop < CMAX) m_drop++;
            if (mv_clr) begin
                m_pass = 0;
                m_drop = 0;
            end
            if (mv_pop) void'(mq.pop_front());
            if (mv_push) mq.push_back(phv_in);
            m_drop_mode = mv_next_drop;
        end
    end

    // Per-cycle compare on the falling edge, away from the active edge.
    always @(negedge clk) begin
        chk("phv_out_valid", phv_out_valid, mq.size() != 0);
        if (mq.size() != 0) chk("phv_out", phv_out, mq[0]);
        chk("stage_ready_out", stage_ready_out, m_drop_mode || (mq.size() < DEPTH));
        chk("pass_cnt", pass_cnt, m_pass);
        chk("drop_cnt", drop_cnt, m_drop);
        chk("c_m_tvalid", c_m_axis_tvalid, m_cv);
        if (m_cv) begin
            chk("c_m_tdata", c_m_axis_tdata, m_cd);
            chk("c_m_tuser", c_m_axis_tuser, m_cu);
            chk("c_m_tkeep", c_m_axis_tkeep, m_ck);
            chk("c_m_tlast", c_m_axis_tlast, m_cl);
        end
        if (areset) begin
            chk("rst_phv_out", phv_out, 0);
            chk("rst_c_m_tdata", c_m_axis_tdata, 0);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] mk(input logic [7:0] id, input logic [1:0] code,
                                       input logic [7:0] lo);
        return {32'hC0DE_0000 | {24'h0, lo}, 14'h0, code, id, lo};
    endfunction

    task automatic beat(input logic [63:0] d, input logic last);
        c_s_axis_tdata  = d;
        c_s_axis_tuser  = d[31:0] ^ 32'h5A5A_5A5A;
        c_s_axis_tkeep  = d[7:0];
        c_s_axis_tlast  = last;
        c_s_axis_tvalid = 1'b1;
        $display("txn ctrl beat tdata=%h last=%0b", d, last);
    endtask

    task automatic idle_ctrl();
        c_s_axis_tvalid = 1'b0;
        c_s_axis_tlast  = 1'b0;
    endtask

    task automatic push_phv(input logic [PL-1:0] v);
        phv_in       = v;
        phv_in_valid = 1'b1;
        $display("txn phv offer %h ready_in=%0b", v, stage_ready_in);
    endtask

    logic [63:0] bd [3];

    initial begin
        areset          = 1'b0;
        phv_in          = '0;
        phv_in_valid    = 1'b0;
        stage_ready_in  = 1'b0;
        c_s_axis_tdata  = '0;
        c_s_axis_tuser  = '0;
        c_s_axis_tkeep  = '0;
        c_s_axis_tvalid = 1'b0;
        c_s_axis_tlast  = 1'b0;
        #2 areset = 1'b1;
        repeat (2) cyc();
        $display("txn reset state");
        chk("reset_valid", phv_out_valid, 0);
        chk("reset_ready", stage_ready_out, 1);
        chk("reset_pass", pass_cnt, 0);
        chk("reset_c_m_tvalid", c_m_axis_tvalid, 0);
        areset = 1'b0;
        cyc();

        // Fill with downstream stalled: 5 offered, 4 accepted.
        stage_ready_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_phv(64'hA000_0000_0000_0000 + 64'(i));
            cyc();
            if (i == 3) chk("fill_full_ready", stage_ready_out, 0);
        end
        phv_in_valid = 1'b0;
        chk("fill_head", phv_out, 64'hA000_0000_0000_0000);
        stage_ready_in = 1'b1;
        repeat (4) cyc();
        chk("fill_pass", pass_cnt, 4);
        chk("fill_empty", phv_out_valid, 0);

        // Streaming: one PHV per cycle, occupancy stays at one.
        for (int i = 0; i < 6; i++) begin
            push_phv(64'hB000_0000_0000_0000 + 64'(i));
            cyc();
            chk("stream_head", phv_out, 64'hB000_0000_0000_0000 + 64'(i));
            chk("stream_ready", stage_ready_out, 1);
        end
        phv_in_valid = 1'b0;
        cyc();
        chk("stream_pass", pass_cnt, 10);

        // Foreign 3-beat packet; the middle beat carries our ID but is not first.
        bd[0] = mk(8'h0F, 2'b01, 8'h11);
        bd[1] = mk(MOD,   2'b01, 8'h22);
        bd[2] = mk(8'h0F, 2'b10, 8'h33);
        for (int i = 0; i < 3; i++) begin
            beat(bd[i], i == 2);
            cyc();
            chk("fwd_tvalid", c_m_axis_tvalid, 1);
            chk("fwd_tdata", c_m_axis_tdata, bd[i]);
            chk("fwd_tlast", c_m_axis_tlast, i == 2);
        end
        idle_ctrl();
        cyc();
        chk("fwd_done_tvalid", c_m_axis_tvalid, 0);

        // DROP config; a PHV in the config cycle is still accepted.
        beat(mk(MOD, 2'b01, 8'h00), 1'b1);
        push_phv(64'hD000_0000_0000_0000);
        cyc();
        idle_ctrl();
        chk("cfg_drop_tvalid", c_m_axis_tvalid, 0);
        chk("cfg_cycle_push", phv_out, 64'hD000_0000_0000_0000);
        for (int i = 1; i < 4; i++) begin
            push_phv(64'hD000_0000_0000_0000 + 64'(i));
            cyc();
        end
        phv_in_valid = 1'b0;
        cyc();
        chk("drop_cnt3", drop_cnt, 3);
        chk("drop_empty", phv_out_valid, 0);
        chk("drop_ready", stage_ready_out, 1);

        // 2-beat config back to NORMAL; second beat is swallowed.
        beat(mk(MOD, 2'b00, 8'h44), 1'b0);
        cyc();
        chk("consume_b1", c_m_axis_tvalid, 0);
        beat(mk(8'h0F, 2'b01, 8'h55), 1'b1);
        cyc();
        chk("consume_b2", c_m_axis_tvalid, 0);
        idle_ctrl();

        // Counter clear, then clear colliding with a pop at pass_cnt=5.
        beat(mk(MOD, 2'b10, 8'h00), 1'b1);
        cyc();
        idle_ctrl();
        chk("clr_pass", pass_cnt, 0);
        chk("clr_drop", drop_cnt, 0);
        for (int i = 0; i < 5; i++) begin
            push_phv(64'hC000_0000_0000_0000 + 64'(i));
            cyc();
        end
        phv_in_valid = 1'b0;
        cyc();
        chk("pre_clr_pass", pass_cnt, 5);
        stage_ready_in = 1'b0;
        push_phv(64'hC000_0000_0000_0005);
        cyc();
        phv_in_valid   = 1'b0;
        stage_ready_in = 1'b1;
        beat(mk(MOD, 2'b10, 8'h01), 1'b1);
        cyc();
        idle_ctrl();
        chk("clr_wins_pass", pass_cnt, 0);
        chk("clr_pop_empty", phv_out_valid, 0);

        // Saturation of both counters.
        for (int i = 0; i < 17; i++) begin
            push_phv(64'hE000_0000_0000_0000 + 64'(i));
            cyc();
        end
        phv_in_valid = 1'b0;
        cyc();
        chk("pass_sat", pass_cnt, CMAX);
        beat(mk(MOD, 2'b11, 8'h00), 1'b1);
        cyc();
        idle_ctrl();
        chk("noop_pass", pass_cnt, CMAX);
        beat(mk(MOD, 2'b01, 8'h00), 1'b1);
        cyc();
        idle_ctrl();
        for (int i = 0; i < 16; i++) begin
            push_phv(64'hE100_0000_0000_0000 + 64'(i));
            cyc();
        end
        phv_in_valid = 1'b0;
        cyc();
        chk("drop_sat", drop_cnt, CMAX);
        beat(mk(MOD, 2'b00, 8'h00), 1'b1);
        cyc();
        idle_ctrl();

        // Reset mid-operation: 3 PHVs buffered, DROP mode, packet in flight.
        stage_ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_phv(64'hF000_0000_0000_0000 + 64'(i));
            cyc();
        end
        phv_in_valid = 1'b0;
        beat(mk(MOD, 2'b01, 8'h00), 1'b1);
        cyc();
        beat(mk(8'h0F, 2'b00, 8'h66), 1'b0);
        cyc();
        idle_ctrl();
        chk("pre_rst_fwd", c_m_axis_tvalid, 1);
        chk("pre_rst_buffered", phv_out_valid, 1);
        #1 areset = 1'b1;
        $display("txn async reset mid-operation");
        #1;
        chk("rst_valid", phv_out_valid, 0);
        chk("rst_c_m", c_m_axis_tvalid, 0);
        chk("rst_pass", pass_cnt, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_ready", stage_ready_out, 1);
        @(negedge clk);
        #1 areset = 1'b0;
        cyc();
        // First post-reset beat is a first beat: our no-op config, not forwarded.
        beat(mk(MOD, 2'b11, 8'h77), 1'b1);
        cyc();
        idle_ctrl();
        chk("post_rst_first_beat", c_m_axis_tvalid, 0);
        // Mode is NORMAL again: filling makes the stage not-ready.
        for (int i = 0; i < 4; i++) begin
            push_phv(64'h1000_0000_0000_0000 + 64'(i));
            cyc();
        end
        phv_in_valid = 1'b0;
        chk("post_rst_normal_full", stage_ready_out, 0);
        stage_ready_in = 1'b1;
        repeat (5) cyc();
        chk("post_rst_pass", pass_cnt, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
